// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared types and constants for the multicycle RV32I control unit.
// Holds the FSM state encoding, opcode values, immediate-type codes, ALU codes
// and the mux select codes driven by multicycle_control.
package multicycle_pkg;

    // Control FSM states; S_TRAP is only reachable when ILLEGAL_INSN_EN is defined
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Immediate extender type codes
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Memory address select
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU A operand select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate type for an opcode; unknown opcodes fall back to the I format
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LW:    imm = IMM_I;
            OP_ITYPE: imm = IMM_I;
            OP_SW:    imm = IMM_S;
            OP_BEQ:   imm = IMM_B;
            OP_JAL:   imm = IMM_J;
            default:  imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: combinational translation of the FSM's coarse ALU request
// (add / sub / decode-from-funct) into the 3-bit ALU control code.
module alu_decoder
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic [1:0]               alu_op,
    input  logic [2:0]               funct3,
    input  logic                     op5,
    input  logic                     funct7b5,
    output logic [ALUCTRL_WIDTH-1:0] alu_control
);

    // sub only for R-type with funct7[5] set; addi with instr[30]=1 stays add
    logic w_is_sub;
    assign w_is_sub = op5 & funct7b5;

    // Decode ALU operation from the FSM request and the funct fields
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (w_is_sub) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle RV32I datapath that
// shares one memory port and one ALU. Supports lw, sw, R-type, I-type ALU,
// beq and jal. Optional macro ILLEGAL_INSN_EN adds an illegal_instr output
// and a sticky TRAP state for unsupported opcodes; without it such opcodes
// retire as NOPs.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OP_WIDTH      = 7,
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     zero,
    input  logic                     mem_ready,
    output logic                     pc_write,
    output logic                     adr_src,
    output logic                     mem_write,
    output logic                     ir_write,
    output logic [1:0]               result_src,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               imm_src,
`ifdef ILLEGAL_INSN_EN
    output logic                     illegal_instr,
`endif
    output logic [ALUCTRL_WIDTH-1:0] alu_control,
    output logic                     reg_write
);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  w_alu_op;
    logic        w_illegal;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Immediate type follows the opcode in every state
    always_comb begin
        imm_src = imm_src_of(op[6:0]);
    end

    // Next-state and Moore output decode; reset shows FETCH selects with all enables off
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        adr_src      = ADR_PC;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        reg_write    = 1'b0;
        w_illegal    = 1'b0;

        if (rst) begin
            w_next_state = S_FETCH;
            adr_src      = ADR_PC;
            alu_src_a    = SRCA_PC;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU;
            w_alu_op     = ALUOP_ADD;
        end else begin
            case (r_state)
                S_FETCH: begin
                    adr_src    = ADR_PC;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    w_alu_op   = ALUOP_ADD;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    if (mem_ready) begin
                        w_next_state = S_DECODE;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch target from the old PC
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    w_alu_op  = ALUOP_ADD;
                    case (op[6:0])
                        OP_LW:    w_next_state = S_MEMADR;
                        OP_SW:    w_next_state = S_MEMADR;
                        OP_RTYPE: w_next_state = S_EXECUTER;
                        OP_ITYPE: w_next_state = S_EXECUTEI;
                        OP_BEQ:   w_next_state = S_BEQ;
                        OP_JAL:   w_next_state = S_JAL;
`ifdef ILLEGAL_INSN_EN
                        default:  w_next_state = S_TRAP;
`else
                        default:  w_next_state = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    w_alu_op  = ALUOP_ADD;
                    if (op[6:0] == OP_LW) begin
                        w_next_state = S_MEMREAD;
                    end else begin
                        w_next_state = S_MEMWRITE;
                    end
                end
                S_MEMREAD: begin
                    adr_src    = ADR_RESULT;
                    result_src = RES_ALUOUT;
                    if (mem_ready) begin
                        w_next_state = S_MEMWB;
                    end else begin
                        w_next_state = S_MEMREAD;
                    end
                end
                S_MEMWB: begin
                    result_src   = RES_MEM;
                    reg_write    = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_MEMWRITE: begin
                    // Strobe held for the whole access until memory accepts it
                    adr_src    = ADR_RESULT;
                    result_src = RES_ALUOUT;
                    mem_write  = 1'b1;
                    if (mem_ready) begin
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_MEMWRITE;
                    end
                end
                S_EXECUTER: begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_RS2;
                    w_alu_op     = ALUOP_FUNCT;
                    w_next_state = S_ALUWB;
                end
                S_EXECUTEI: begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_IMM;
                    w_alu_op     = ALUOP_FUNCT;
                    w_next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src   = RES_ALUOUT;
                    reg_write    = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_BEQ: begin
                    // Branch target was latched during DECODE; take it on equality
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_RS2;
                    w_alu_op     = ALUOP_SUB;
                    result_src   = RES_ALUOUT;
                    pc_write     = zero;
                    w_next_state = S_FETCH;
                end
                S_JAL: begin
                    // PC takes the DECODE target; ALU forms old PC + 4 for rd
                    alu_src_a    = SRCA_OLDPC;
                    alu_src_b    = SRCB_FOUR;
                    w_alu_op     = ALUOP_ADD;
                    result_src   = RES_ALUOUT;
                    pc_write     = 1'b1;
                    w_next_state = S_ALUWB;
                end
                S_TRAP: begin
                    w_illegal    = 1'b1;
                    w_next_state = S_TRAP;
                end
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end
    end

`ifdef ILLEGAL_INSN_EN
    assign illegal_instr = w_illegal;
`else
    logic w_unused;
    assign w_unused = w_illegal;
`endif

    alu_decoder #(
        .ALUCTRL_WIDTH (ALUCTRL_WIDTH)
    ) u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control.
// Inputs change on the falling edge; outputs are checked 1 ns later, mid-cycle.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       reg_write;
`ifdef ILLEGAL_INSN_EN
    logic       illegal_instr;
`endif

    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
`ifdef ILLEGAL_INSN_EN
        .illegal_instr (illegal_instr),
`endif
        .alu_control (alu_control),
        .reg_write   (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed: pcw adr mw irw | rs sa sb imm | alu | rw
    logic [15:0] obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                  alu_src_a, alu_src_b, imm_src, alu_control, reg_write};

    function automatic logic [15:0] pk(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] im,
                                       input logic [2:0] al, input logic rw);
        return {pcw, adr, mw, irw, rs, sa, sb, im, al, rw};
    endfunction

    // Check outputs mid-cycle, then advance to the next falling edge
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    // FETCH (memory ready) followed by DECODE for the current opcode
    task automatic fd(input string tag, input logic [1:0] im);
        cyc({tag, "_fetch"},  pk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, im, 3'b000, 1'b0));
        cyc({tag, "_decode"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, 3'b000, 1'b0));
    endtask

`ifdef ILLEGAL_INSN_EN
    task automatic chk_illegal(input string tag, input logic exp);
        #1;
        checks++;
        assert (illegal_instr === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, illegal_instr, exp);
        end
    endtask
`endif

    logic [15:0] v_rst;

    initial begin
        v_rst     = 16'b0000_10_00_10_00_000_0;
        rst       = 1'b1;
        op        = 7'b0000011;
        funct3    = 3'b000;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);

        // Reset: enables off, FETCH selects visible
        cyc("rst_0", v_rst);
        cyc("rst_1", v_rst);
        rst = 1'b0;

        // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
        fd("lw", 2'b00);
        cyc("lw_memadr",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        cyc("lw_memread", pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc("lw_memwb",   pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // sw: one FETCH wait, then MEMWRITE held for 3 not-ready cycles
        op = 7'b0100011;
        mem_ready = 1'b0;
        cyc("sw_fetch_wait", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0));
        mem_ready = 1'b1;
        fd("sw", 2'b01);
        cyc("sw_memadr", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0));
        mem_ready = 1'b0;
        cyc("sw_memwrite_w0", pk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));
        cyc("sw_memwrite_w1", pk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));
        cyc("sw_memwrite_w2", pk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));
        mem_ready = 1'b1;
        cyc("sw_memwrite_rdy", pk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        fd("sub", 2'b00);
        cyc("sub_exec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0));
        cyc("sub_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // R-type and / slt
        funct3 = 3'b111; funct7b5 = 1'b0;
        fd("and", 2'b00);
        cyc("and_exec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 1'b0));
        cyc("and_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
        funct3 = 3'b010;
        fd("slt", 2'b00);
        cyc("slt_exec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 1'b0));
        cyc("slt_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // I-type addi with instr[30]=1 must stay add (op[5]=0)
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        fd("addi", 2'b00);
        cyc("addi_exec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        cyc("addi_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
        funct3 = 3'b110; funct7b5 = 1'b0;
        fd("ori", 2'b00);
        cyc("ori_exec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 1'b0));
        cyc("ori_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
        funct3 = 3'b001;
        fd("slli", 2'b00);
        cyc("slli_exec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        cyc("slli_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // beq taken then not taken
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        fd("beq_t", 2'b10);
        cyc("beq_t_beq", pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0));
        zero = 1'b0;
        fd("beq_n", 2'b10);
        cyc("beq_n_beq", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0));

        // jal
        op = 7'b1101111;
        fd("jal", 2'b11);
        cyc("jal_jal",   pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0));
        cyc("jal_aluwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b1));

        // Unsupported opcode
        op = 7'b0000000;
        fd("ill", 2'b00);
`ifdef ILLEGAL_INSN_EN
        chk_illegal("ill_flag_0", 1'b1);
        cyc("ill_trap_0", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        chk_illegal("ill_flag_1", 1'b1);
        cyc("ill_trap_1", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        chk_illegal("ill_flag_2", 1'b1);
        cyc("ill_trap_2", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        rst = 1'b1;
        chk_illegal("ill_flag_rst", 1'b0);
        cyc("ill_rst", v_rst);
`else
        cyc("ill_nop_fetch", pk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0));
        rst = 1'b1;
        cyc("ill_rst", v_rst);
`endif
        rst = 1'b0;

        // Reset in MEMREAD (after one wait) must not reach MEMWB
        op = 7'b0000011;
        fd("lwr", 2'b00);
        cyc("lwr_memadr", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        mem_ready = 1'b0;
        cyc("lwr_memread_wait", pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        mem_ready = 1'b1;
        rst = 1'b1;
        cyc("lwr_rst", v_rst);
        rst = 1'b0;
        cyc("lwr_after_rst_fetch", pk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM that turns the single-cycle RV32I datapath into a multicycle one sharing a single memory port and a single ALU.
- Sequences fetch, decode, address-generation, memory access, execute and writeback steps, one step per cycle.
- Drives imm_src to the immediate extender and all other mux selects, enables and ALU control.
- Supports lw, sw, R-type (add/sub/and/or/slt), addi-class I-type, beq and jal.
- Waits on a memory ready handshake.

Parameters:
- OP_WIDTH, 7, opcode field width.
- ALUCTRL_WIDTH, 3, ALU control code width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  7  instr[6:0], taken from the instruction register.
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction-register and old-PC enable.
- result_src  output  2  result mux select: 00 = ALU result register, 01 = memory data, 10 = ALU output.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = imm_ext, 10 = constant 4.
- imm_src  output  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- reg_write  output  1  register file write enable.

Behaviour:
- Clocking: one clock domain (clk). rst is synchronous and active-high; while rst is high the state is forced to FETCH.
- Moore outputs: all outputs are decoded from state; pc_write also depends on zero and mem_ready. Any output not listed for a state is 0.
- Reset values: state = FETCH. While rst = 1, pc_write, ir_write, mem_write and reg_write are forced to 0. The select outputs show their FETCH values: adr_src = 0, alu_src_a = 00, alu_src_b = 10, result_src = 10, alu_control = 000.
- imm_src: decoded combinationally from op in every state.
  - lw (0000011) and I-type ALU (0010011) -> 00.
  - sw (0100011) -> 01.
  - beq (1100011) -> 10.
  - jal (1101111) -> 11.
  - Any other opcode -> 00.
- States and transitions:
  - FETCH: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu add, result_src = 10. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
  - DECODE: alu_src_a = 01, alu_src_b = 01, alu add (precomputes the branch target). Next state by op:
    - lw or sw -> MEMADR.
    - R-type (0110011) -> EXECUTER.
    - I-type ALU -> EXECUTEI.
    - beq -> BEQ.
    - jal -> JAL.
    - Other opcodes: see Optional Feature.
  - MEMADR: alu_src_a = 10, alu_src_b = 01, add. Next state MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD: adr_src = 1, result_src = 00. Hold until mem_ready = 1, then go to MEMWB.
  - MEMWB: result_src = 01, reg_write = 1. Next state FETCH.
  - MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1 for every cycle until mem_ready = 1, then go to FETCH.
  - EXECUTER: alu_src_a = 10, alu_src_b = 00, alu decoded from funct fields. Next state ALUWB.
  - EXECUTEI: alu_src_a = 10, alu_src_b = 01, alu decoded from funct fields. Next state ALUWB.
  - ALUWB: result_src = 00, reg_write = 1. Next state FETCH.
  - BEQ: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00, pc_write = zero. Next state FETCH.
  - JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1. Next state ALUWB (rd receives PC+4).
- ALU decode (funct-field decode, used in EXECUTER and EXECUTEI):
  - funct3 000 -> sub if (op[5] & funct7b5), else add.
  - funct3 010 -> slt.
  - funct3 110 -> or.
  - funct3 111 -> and.
  - Other funct3 -> add.
- Latencies with mem_ready always 1:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-type: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
- Memory wait: each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. While waiting, all outputs hold their state values and no enable pulses beyond those listed above.
- Reset mid-instruction: the state returns to FETCH on the next edge, with no partial writeback.

Optional Feature:
- Macro: ILLEGAL_INSN_EN.
- Defined:
  - Adds output illegal_instr (1 bit, reset 0).
  - An unsupported opcode in DECODE goes to state TRAP.
  - TRAP holds forever with all enables at 0 and illegal_instr = 1, until rst.
- Undefined:
  - An unsupported opcode in DECODE returns to FETCH (treated as a NOP).
  - No extra port.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum;
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL);
  - imm_src codes (IMM_I, IMM_S, IMM_B, IMM_J);
  - alu_control codes;
  - select-code constants for adr_src, result_src, alu_src_a and alu_src_b.
- Sub-module alu_decoder: purely combinational. Inputs alu_op (2 bits: 00 add, 01 sub, 10 funct), funct3, op[5] and funct7b5; output alu_control.

Test Plan:
- rst high for 2 cycles, then op = lw, mem_ready = 1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write = 1 only in cycle 5, with result_src = 01.
- op = sw, mem_ready held 0 for 3 cycles in MEMWRITE -> mem_write = 1 for 4 consecutive cycles, then FETCH. imm_src = 01 throughout.
- op = 0110011, funct3 = 000, funct7b5 = 1 -> alu_control = 001 in EXECUTER, then reg_write = 1 in ALUWB.
- op = beq with zero = 1, then with zero = 0 -> pc_write = 1 and 0 respectively in BEQ. imm_src = 10.
- op = jal -> imm_src = 11, pc_write = 1 in JAL, then reg_write = 1 in ALUWB.
- op = 0000000 -> with ILLEGAL_INSN_EN: TRAP and illegal_instr = 1 until rst. Without it: FETCH follows DECODE.
